// File: rtl/definitions.sv
// Shared types for the ALU sequencer: opcodes, instruction word, sequencer state,
// and a reference shift-add multiply that the iterative datapath matches bit for bit.
package definitions;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2
    } opcodes_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        opcodes_t    opcode;
    } instruction_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } seq_state_t;

    // Digit-serial multiply from the LSB of b; bits above 31 fall off every step.
    function automatic logic [31:0] multiplier(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int          radix_bits);
        logic [31:0] acc;
        logic [31:0] a_sh;
        logic [31:0] b_sh;
        logic [31:0] digit_mask;
        acc        = '0;
        a_sh       = a;
        b_sh       = b;
        digit_mask = (32'd1 << radix_bits) - 32'd1;
        for (int i = 0; i < 32 / radix_bits; i++) begin
            acc  = acc + a_sh * (b_sh & digit_mask);
            a_sh = a_sh << radix_bits;
            b_sh = b_sh >> radix_bits;
        end
        return acc;
    endfunction

endpackage

// File: rtl/alu_sequencer_mul_iter.sv
// Iterative multiplier datapath: retires RADIX_BITS bits of b per step into a
// 32-bit accumulator; done flags the final step so the caller can capture product.
module mul_iter
    import definitions::*;
#(
    parameter int RADIX_BITS = 1,
    parameter int STEPS      = 32 / RADIX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        step_en,
    output logic        done,
    output logic [31:0] product
);

    localparam int CNT_W = $clog2(STEPS);

    logic [31:0]      acc_q, acc_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      digit;
    logic [31:0]      partial;

    // The counter holds on the last step instead of wrapping.
    always_comb begin
        digit   = 32'(b_q[RADIX_BITS-1:0]);
        partial = a_q * digit;
        product = acc_q + partial;
        done    = step_en && (count_q == CNT_W'(STEPS - 1));
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        count_d = count_q;
        if (start) begin
            acc_d   = '0;
            a_d     = a;
            b_d     = b;
            count_d = '0;
        end else if (step_en) begin
            acc_d = product;
            a_d   = a_q << RADIX_BITS;
            b_d   = b_q >> RADIX_BITS;
            if (!done) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue ALU sequencer: ADD/SUB/illegal complete on the accepting edge,
// MUL hands off to mul_iter and stalls intake until the product is captured.
module alu_sequencer
    import definitions::*;
#(
    parameter int MUL_RADIX_BITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    input  instruction_t instr,
    output logic         instr_ready,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result,
    output opcodes_t     result_op,
    output logic         result_err,
    output logic         busy
);

    localparam int MUL_STEPS = 32 / MUL_RADIX_BITS;

    seq_state_t  state_q, state_d;
    logic [31:0] result_q, result_d;
    opcodes_t    result_op_q, result_op_d;
    logic        result_err_q, result_err_d;
    logic        result_valid_q, result_valid_d;
    logic        accept;
    logic        mul_start;
    logic        mul_step;
    logic        mul_done;
    logic [31:0] mul_product;

    mul_iter #(
        .RADIX_BITS(MUL_RADIX_BITS),
        .STEPS     (MUL_STEPS)
    ) u_mul_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (instr.a),
        .b      (instr.b),
        .step_en(mul_step),
        .done   (mul_done),
        .product(mul_product)
    );

    // A pending result may drain on the same edge a new instruction is taken.
    always_comb begin
        instr_ready    = !rst && (state_q == IDLE) && (!result_valid_q || result_ready);
        accept         = instr_valid && instr_ready;
        mul_start      = accept && (instr.opcode == MUL);
        mul_step       = (state_q == MUL_RUN);
        state_d        = state_q;
        result_d       = result_q;
        result_op_d    = result_op_q;
        result_err_d   = result_err_q;
        result_valid_d = result_valid_q && !result_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    result_op_d = instr.opcode;
                    case (instr.opcode)
                        ADD: begin
                            result_d       = instr.a + instr.b;
                            result_err_d   = 1'b0;
                            result_valid_d = 1'b1;
                        end
                        SUB: begin
                            result_d       = instr.a - instr.b;
                            result_err_d   = 1'b0;
                            result_valid_d = 1'b1;
                        end
                        MUL: begin
                            state_d = MUL_RUN;
                        end
                        default: begin
                            result_d       = '0;
                            result_err_d   = 1'b1;
                            result_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL_RUN: begin
                if (mul_done) begin
                    state_d        = IDLE;
                    result_d       = mul_product;
                    result_op_d    = MUL;
                    result_err_d   = 1'b0;
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            result_q       <= '0;
            result_op_q    <= ADD;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_op_q    <= result_op_d;
            result_err_q   <= result_err_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign result_op    = result_op_q;
    assign result_err   = result_err_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == MUL_RUN);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected results are queued as instructions
// are issued and popped when the DUT presents them; a second instance covers radix 4.
module tb_alu_sequencer;
    import definitions::*;

    typedef struct {
        logic [31:0] res;
        opcodes_t    op;
        logic        err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         instr_valid;
    instruction_t instr;
    logic         instr_ready;
    logic         result_valid;
    logic         result_ready;
    logic [31:0]  result;
    opcodes_t     result_op;
    logic         result_err;
    logic         busy;

    logic         i4_valid;
    instruction_t i4_instr;
    logic         i4_ready;
    logic         r4_valid;
    logic         r4_rready;
    logic [31:0]  r4_result;
    opcodes_t     r4_op;
    logic         r4_err;
    logic         r4_busy;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result      (result),
        .result_op   (result_op),
        .result_err  (result_err),
        .busy        (busy)
    );

    alu_sequencer #(.MUL_RADIX_BITS(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (i4_valid),
        .instr       (i4_instr),
        .instr_ready (i4_ready),
        .result_valid(r4_valid),
        .result_ready(r4_rready),
        .result      (r4_result),
        .result_op   (r4_op),
        .result_err  (r4_err),
        .busy        (r4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction across one edge and queues what it should produce.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input opcodes_t op);
        exp_t e;
        instr_valid  = 1'b1;
        instr.a      = a;
        instr.b      = b;
        instr.opcode = op;
        e.op  = op;
        e.err = 1'b0;
        case (op)
            ADD:     e.res = a + b;
            SUB:     e.res = a - b;
            MUL:     e.res = a * b;
            default: begin e.res = 32'd0; e.err = 1'b1; end
        endcase
        sb.push_back(e);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        result_ready = 1'b1;
        i4_valid     = 1'b0;
        i4_instr     = '0;
        r4_rready    = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (result_valid !== 1'b0 || result !== 32'd0 || result_op !== ADD ||
            result_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got v=%0b r=%h op=%0d err=%0b busy=%0b, want 0 0 0 0 0",
                     result_valid, result, result_op, result_err, busy);
        end
        n_cmp++;
        if (instr_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ready_in_reset: got %0b, want 0", instr_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || i4_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL ready_after_reset: got %0b/%0b, want 1/1", instr_ready, i4_ready);
        end
    endtask

    task automatic test_add();
        exp_t e;
        result_ready = 1'b1;
        send(32'd5, 32'd7, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== e.res || result_op !== e.op || result_err !== e.err) begin
            n_bad++;
            $display("[TB] FAIL add: got v=%0b r=%h op=%0d err=%0b, want v=1 r=%h op=%0d err=%0b",
                     result_valid, result, result_op, result_err, e.res, e.op, e.err);
        end
        tick();
        n_cmp++;
        if (result_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL add_one_cycle: got valid=%0b, want 0", result_valid);
        end
    endtask

    task automatic test_sub();
        exp_t e;
        send(32'd3, 32'd5, SUB);
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== 32'hFFFF_FFFE || result !== e.res ||
            result_op !== SUB || result_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL sub: got v=%0b r=%h op=%0d err=%0b, want v=1 r=fffffffe op=1 err=0",
                     result_valid, result, result_op, result_err);
        end
        tick();
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat = 0;
        int   busy_cycles = 0;
        int   ready_hi = 0;
        send(a, b, MUL);
        while (result_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (instr_ready !== 1'b0) ready_hi++;
            instr.a      = $urandom;
            instr.b      = $urandom;
            instr.opcode = ADD;
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 32) begin
            n_bad++;
            $display("[TB] FAIL mul_latency: got %0d edges, want 32", lat);
        end
        n_cmp++;
        if (busy_cycles != 32 || ready_hi != 0) begin
            n_bad++;
            $display("[TB] FAIL mul_busy: got busy=%0d ready_hi=%0d, want 32 and 0", busy_cycles, ready_hi);
        end
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== e.res || result_op !== e.op ||
            result_err !== e.err || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mul_result: got v=%0b r=%h op=%0d err=%0b busy=%0b, want v=1 r=%h op=%0d err=%0b busy=0",
                     result_valid, result, result_op, result_err, busy, e.res, e.op, e.err);
        end
        tick();
    endtask

    task automatic test_mul_radix4();
        int lat = 0;
        int busy_cycles = 0;
        i4_valid        = 1'b1;
        i4_instr.a      = 32'h0000_FFFF;
        i4_instr.b      = 32'h0001_0001;
        i4_instr.opcode = MUL;
        tick();
        i4_valid = 1'b0;
        while (r4_valid !== 1'b1 && lat < 20) begin
            if (r4_busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 8 || busy_cycles != 8) begin
            n_bad++;
            $display("[TB] FAIL mul_radix4_latency: got lat=%0d busy=%0d, want 8 and 8", lat, busy_cycles);
        end
        n_cmp++;
        if (r4_result !== 32'hFFFF_FFFF || r4_op !== MUL || r4_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mul_radix4_result: got r=%h op=%0d err=%0b, want ffffffff 2 0",
                     r4_result, r4_op, r4_err);
        end
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   holds_bad = 0;
        result_ready = 1'b0;
        send(32'd1, 32'd1, ADD);
        instr_valid  = 1'b1;
        instr.a      = 32'd2;
        instr.b      = 32'd2;
        instr.opcode = ADD;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (result_valid !== 1'b1 || result !== 32'd2 || result_op !== ADD || instr_ready !== 1'b0)
                holds_bad++;
            tick();
        end
        n_cmp++;
        if (holds_bad != 0) begin
            n_bad++;
            $display("[TB] FAIL backpressure_hold: got %0d bad cycles, want 0", holds_bad);
        end
        result_ready = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL backpressure_drain_ready: got %0b, want 1", instr_ready);
        end
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== e.res) begin
            n_bad++;
            $display("[TB] FAIL backpressure_first: got v=%0b r=%h, want v=1 r=%h", result_valid, result, e.res);
        end
        send(32'd2, 32'd2, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== e.res || result_op !== e.op) begin
            n_bad++;
            $display("[TB] FAIL backpressure_second: got v=%0b r=%h op=%0d, want v=1 r=%h op=%0d",
                     result_valid, result, result_op, e.res, e.op);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   not_ready = 0;
        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (instr_ready !== 1'b1) not_ready++;
            send($urandom, $urandom, (i % 2 == 1) ? SUB : ADD);
            e = sb.pop_front();
            n_cmp++;
            if (result_valid !== 1'b1 || result !== e.res || result_op !== e.op || result_err !== e.err) begin
                n_bad++;
                $display("[TB] FAIL back_to_back[%0d]: got v=%0b r=%h op=%0d, want v=1 r=%h op=%0d",
                         i, result_valid, result, result_op, e.res, e.op);
            end
        end
        n_cmp++;
        if (not_ready != 0) begin
            n_bad++;
            $display("[TB] FAIL back_to_back_ready: got %0d stalls, want 0", not_ready);
        end
        tick();
    endtask

    task automatic test_illegal();
        exp_t e;
        send(32'd10, 32'd20, opcodes_t'(2'd3));
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== 32'd0 || result_err !== 1'b1 || result_op !== e.op) begin
            n_bad++;
            $display("[TB] FAIL illegal: got v=%0b r=%h op=%0d err=%0b, want v=1 r=0 op=3 err=1",
                     result_valid, result, result_op, result_err);
        end
        tick();
        test_mul(32'd6, 32'd7);
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int   seen = 0;
        send(32'd6, 32'd7, MUL);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        sb.delete();
        n_cmp++;
        if (result_valid !== 1'b0 || result !== 32'd0 || result_op !== ADD || result_err !== 1'b0 ||
            busy !== 1'b0 || instr_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_mul: got v=%0b r=%h op=%0d err=%0b busy=%0b rdy=%0b, want all 0",
                     result_valid, result, result_op, result_err, busy, instr_ready);
        end
        rst = 1'b0;
        repeat (40) begin
            if (result_valid !== 1'b0) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("[TB] FAIL reset_abandon: got %0d valid cycles, want 0", seen);
        end
        send(32'd1, 32'd2, ADD);
        e = sb.pop_front();
        n_cmp++;
        if (result_valid !== 1'b1 || result !== e.res || result !== 32'd3) begin
            n_bad++;
            $display("[TB] FAIL reset_then_add: got v=%0b r=%h, want v=1 r=00000003", result_valid, result);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul(32'h0000_FFFF, 32'h0001_0001);
        test_mul_radix4();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
